// File: rtl/hex_to_seg.sv
// Hex nibble to 7-segment decoder for one digit, with blanking and lamp test.
// Segment order is {g,f,e,d,c,b,a}; polarity and output registering are parameters.
module hex_to_seg #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hex_data,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg_data
);

  localparam logic [6:0] LIT_ALL  = 7'h7F;
  localparam logic [6:0] LIT_NONE = 7'h00;

  // Active-high lit pattern; b and d are lowercase to stay distinct from 8 and 0.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] lit;
    case (nib)
      4'h0:    lit = 7'h3F;
      4'h1:    lit = 7'h06;
      4'h2:    lit = 7'h5B;
      4'h3:    lit = 7'h4F;
      4'h4:    lit = 7'h66;
      4'h5:    lit = 7'h6D;
      4'h6:    lit = 7'h7D;
      4'h7:    lit = 7'h07;
      4'h8:    lit = 7'h7F;
      4'h9:    lit = 7'h6F;
      4'hA:    lit = 7'h77;
      4'hB:    lit = 7'h7C;
      4'hC:    lit = 7'h39;
      4'hD:    lit = 7'h5E;
      4'hE:    lit = 7'h79;
      4'hF:    lit = 7'h71;
      default: lit = LIT_NONE;
    endcase
    return lit;
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] lit);
    return ACTIVE_LOW ? ~lit : lit;
  endfunction

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? ~LIT_NONE : LIT_NONE;

  logic [6:0] lit_sel;
  logic [6:0] seg_sel;

  always_comb begin
    lit_sel = decode(hex_data);
    if (lamp_test) begin
      lit_sel = LIT_ALL;
    end else if (blank) begin
      lit_sel = LIT_NONE;
    end
    seg_sel = polarity(lit_sel);
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [6:0] seg_p1;

      // Stage boundary: selected pattern registered to the display pins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_p1 <= SEG_OFF;
        end else begin
          seg_p1 <= seg_sel;
        end
      end

      assign seg_data = seg_p1;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign seg_data       = seg_sel;
    end
  endgenerate

endmodule

// File: tb/tb_hex_to_seg.sv
// Directed bench for hex_to_seg: registered active-low instance plus a
// combinational active-high instance.
module tb_hex_to_seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] hex_data = 4'h8;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] seg_data;

  logic [3:0] hex_c = 4'h0;
  logic       blank_c = 1'b0;
  logic       lamp_c = 1'b0;
  logic [6:0] seg_c;

  int checks = 0;
  int errors = 0;

  logic [6:0] al_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_to_seg #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .hex_data(hex_data), .blank(blank),
    .lamp_test(lamp_test), .seg_data(seg_data)
  );

  hex_to_seg #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .hex_data(hex_c), .blank(blank_c),
    .lamp_test(lamp_c), .seg_data(seg_c)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted between edges must act without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", seg_data, 7'h7F);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check("reset_hold", seg_data, 7'h7F);
    end

    // Release reset, then walk 0..F, one value per 200 ns.
    @(negedge clk);
    rst_n    = 1'b1;
    hex_data = 4'h0;
    #1;
    check("release_no_edge", seg_data, 7'h7F);
    for (int v = 0; v < 16; v++) begin
      if (v != 0) begin
        @(negedge clk);
        hex_data = 4'(v);
        #1;
        check("latency_old_value", seg_data, al_tab[v-1]);
      end
      edge_sample();
      check($sformatf("decode_%0h", v), seg_data, al_tab[v]);
      repeat (19) @(posedge clk);
      #1;
      check($sformatf("stable_%0h", v), seg_data, al_tab[v]);
    end

    @(negedge clk);
    hex_data = 4'h0;
    edge_sample();
    check("wrap_f_to_0", seg_data, 7'h40);

    // Blanking.
    @(negedge clk);
    hex_data = 4'h8;
    edge_sample();
    check("eight", seg_data, 7'h00);
    @(negedge clk);
    blank = 1'b1;
    edge_sample();
    check("blank_on", seg_data, 7'h7F);
    @(negedge clk);
    blank = 1'b0;
    edge_sample();
    check("blank_off", seg_data, 7'h00);

    // Lamp test beats blank and data.
    @(negedge clk);
    blank    = 1'b1;
    hex_data = 4'h1;
    edge_sample();
    check("blank_over_one", seg_data, 7'h7F);
    @(negedge clk);
    lamp_test = 1'b1;
    edge_sample();
    check("lamp_over_blank", seg_data, 7'h00);
    @(negedge clk);
    lamp_test = 1'b0;
    edge_sample();
    check("lamp_off_blank", seg_data, 7'h7F);
    @(negedge clk);
    blank = 1'b0;
    edge_sample();
    check("one_after_blank", seg_data, 7'h79);

    // Short reset pulse mid-stream.
    @(negedge clk);
    hex_data = 4'h5;
    edge_sample();
    check("five", seg_data, 7'h12);
    #1;
    rst_n = 1'b0;
    #1;
    check("pulse_immediate", seg_data, 7'h7F);
    #2;
    rst_n = 1'b1;
    #1;
    check("pulse_released_no_edge", seg_data, 7'h7F);
    edge_sample();
    check("pulse_resume", seg_data, 7'h12);

    // Combinational active-high instance.
    hex_c = 4'hA;
    #1;
    check("comb_A", seg_c, 7'h77);
    hex_c = 4'hD;
    #1;
    check("comb_d", seg_c, 7'h5E);
    blank_c = 1'b1;
    #1;
    check("comb_blank", seg_c, 7'h00);
    lamp_c = 1'b1;
    #1;
    check("comb_lamp", seg_c, 7'h7F);
    lamp_c  = 1'b0;
    blank_c = 1'b0;
    hex_c   = 4'h2;
    #1;
    check("comb_2", seg_c, 7'h5B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
